// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch engine (state enum, XLEN, INSTR_BYTES, NOP)
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_BYTES = 4;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;
    typedef enum logic {FETCH, DRAIN} state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response, redirect and decode handshake bundle; master = fetch unit, slave = memory/decode/branch side
interface fetch_if;
    import fetch_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_instr;
    logic [XLEN-1:0] if_pc;
    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_instr, if_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: sync FIFO of {pc,instr} entries; clk, rst (active-low sync), push/din, pop/dout, clear, count/full/empty
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign dout = mem[rptr];
    always_ff @(posedge clk)
        if (push && !clear) mem[wptr] <= din;
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            wptr <= push ? wptr + AW'(1) : wptr;
            rptr <= pop ? rptr + AW'(1) : rptr;
            count <= count + CW'(push) - CW'(pop);
        end
    end
    assert property (@(posedge clk) disable iff (!rst || clear) !(push && full && !pop));
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: credit-limited in-order instruction fetch with prefetch FIFO and redirect flush; clk, rst (active-low sync), bus (fetch_if.master)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VALUE = 32'h0000_0000,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input logic      clk,
    input logic      rst,
    fetch_if.master  bus
);
    localparam int OW = $clog2(MAX_OUTSTANDING+1);
    localparam int CW = $clog2(FIFO_DEPTH+1);
    state_t state;
    logic [XLEN-1:0] fetch_pc, resp_pc;
    logic [OW-1:0] outstanding, discard, discard_n;
    logic [CW-1:0] count;
    logic [2*XLEN-1:0] head;
    logic empty, full, push, pop, req_valid, accept;
    // FIFO slots are reserved at issue time, so a response always has room
    assign req_valid = rst && state == FETCH && !bus.redirect_valid && !full
                       && int'(outstanding) < MAX_OUTSTANDING
                       && int'(count) + int'(outstanding) < FIFO_DEPTH;
    assign accept = req_valid && bus.imem_req_ready;
    assign push = bus.imem_resp_valid && !bus.redirect_valid && discard == '0;
    assign pop = !empty && bus.if_ready && !bus.redirect_valid;
    // a response landing with the redirect is already stale, so it is not counted
    assign discard_n = bus.redirect_valid ? outstanding - OW'(bus.imem_resp_valid)
                                          : discard - OW'(bus.imem_resp_valid && discard != '0);
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr = fetch_pc;
    assign bus.if_valid = !empty;
    assign bus.if_pc = empty ? '0 : head[2*XLEN-1:XLEN];
    assign bus.if_instr = empty ? '0 : head[XLEN-1:0];
    fetch_fifo #(.DEPTH(FIFO_DEPTH), .W(2*XLEN)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(bus.redirect_valid),
        .din({resp_pc, bus.imem_resp_data}), .dout(head), .count(count), .full(full), .empty(empty)
    );
    // responses are in order and requests sequential, so the PC of the next kept
    // response is simply the redirect target plus 4 per word already kept
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= FETCH;
            fetch_pc <= RESET_VALUE;
            resp_pc <= RESET_VALUE;
            outstanding <= '0;
            discard <= '0;
        end else begin
            outstanding <= outstanding + OW'(accept) - OW'(bus.imem_resp_valid);
            discard <= discard_n;
            state <= discard_n != '0 ? DRAIN : FETCH;
            fetch_pc <= bus.redirect_valid ? bus.redirect_pc & ~XLEN'(3)
                      : accept ? fetch_pc + XLEN'(INSTR_BYTES) : fetch_pc;
            resp_pc <= bus.redirect_valid ? bus.redirect_pc & ~XLEN'(3)
                     : push ? resp_pc + XLEN'(INSTR_BYTES) : resp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: random-stimulus scoreboard bench for fetch_unit with memory and decode models
module tb_fetch_unit;
    localparam logic [31:0] RV = 32'h0000_0000;
    localparam int DEPTH = 4;
    localparam int MAXO = 4;
    logic clk = 0;
    logic rst = 0;
    fetch_if bus();
    fetch_unit #(.RESET_VALUE(RV), .FIFO_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;
    int ready_pct = 100, ifr_pct = 100, lat = 1;
    int cyc = 0, n_acc = 0, n_hs = 0, occ = 0, stale = 0;
    int occ_pre, pend_pre, stale_pre;
    logic [31:0] exp_req = RV;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int pend_due[$];
    logic prev_stall = 0;
    logic [31:0] prev_addr = 0;
    logic [31:0] mon_e;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5677;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // instruction memory: in-order, fixed latency per request, random ready
    initial begin
        bus.imem_req_ready = 0;
        bus.imem_resp_valid = 0;
        bus.imem_resp_data = 0;
        forever begin
            @(negedge clk);
            cyc++;
            occ_pre = occ;
            stale_pre = stale;
            pend_pre = pend_addr.size();
            bus.imem_resp_valid = 0;
            if (!rst) begin
                pend_addr.delete();
                pend_due.delete();
                stale = 0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                bus.imem_resp_valid = 1;
                bus.imem_resp_data = memfn(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            bus.imem_req_ready = $urandom_range(99) < ready_pct;
            #1;
            if (bus.redirect_valid) stale = pend_addr.size();
            else if (bus.imem_resp_valid) begin
                if (stale > 0) stale--;
                else occ++;
            end
            if (prev_stall && rst && !bus.redirect_valid) begin
                check("stall_valid", bus.imem_req_valid, 1);
                check("stall_addr", bus.imem_req_addr, prev_addr);
            end
            prev_stall = rst && bus.imem_req_valid && !bus.imem_req_ready;
            prev_addr = bus.imem_req_addr;
            if (rst && bus.imem_req_valid && bus.imem_req_ready) begin
                check("req_addr", bus.imem_req_addr, exp_req);
                check("req_in_redirect", bus.redirect_valid, 0);
                check("req_in_drain", stale_pre, 0);
                check("req_credit", occ_pre + pend_pre < DEPTH, 1);
                check("req_max_out", pend_pre < MAXO, 1);
                exp_q.push_back(exp_req);
                exp_req += 4;
                pend_addr.push_back(bus.imem_req_addr);
                pend_due.push_back(cyc + lat);
                n_acc++;
            end
        end
    end

    // decode side: random ready, pops expected PC on every accepted instruction
    initial begin
        bus.if_ready = 0;
        forever begin
            @(negedge clk);
            bus.if_ready = $urandom_range(99) < ifr_pct;
            #1;
            if (rst && !bus.redirect_valid && bus.if_valid && bus.if_ready) begin
                n_hs++;
                occ--;
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL if_unexpected: got pc %h want no instruction", bus.if_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("if_pc", bus.if_pc, mon_e);
                    check("if_instr", bus.if_instr, memfn(mon_e));
                end
            end
        end
    end

    task automatic do_reset();
        tick(1);
        rst = 0;
        exp_q.delete();
        exp_req = RV;
        occ = 0;
        stale = 0;
        n_acc = 0;
        tick(1);
        #1;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_req_addr", bus.imem_req_addr, RV);
        check("rst_if_valid", bus.if_valid, 0);
        check("rst_if_instr", bus.if_instr, 0);
        check("rst_if_pc", bus.if_pc, 0);
        rst = 1;
    endtask

    task automatic do_redirect(logic [31:0] pc);
        bus.redirect_valid = 1;
        bus.redirect_pc = pc;
        exp_q.delete();
        exp_req = pc & ~32'h3;
        occ = 0;
        tick(1);
        bus.redirect_valid = 0;
        #1;
        check("if_valid_after_redirect", bus.if_valid, 0);
    endtask

    initial begin
        int t, h0;
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, h0;
        bus.redirect_valid = 0;
        bus.redirect_pc = 0;
        tick(2);
        // streaming at full rate
        do_reset();
        tick(10);
        h0 = n_hs;
        tick(30);
        check("throughput", n_hs - h0, 30);
        // decode stalled: FIFO fills to exactly DEPTH and fetch stops
        ifr_pct = 0;
        do_reset();
        tick(20);
        check("buffered_words", occ, DEPTH);
        check("full_req_valid", bus.imem_req_valid, 0);
        check("full_outstanding", pend_addr.size(), 0);
        check("full_head_pc", bus.if_pc, 32'h0);
        ifr_pct = 100;
        tick(10);
        check("resume_delivered", n_hs - h0 >= 34, 1);
        // memory backpressure: address held at 0x8
        ready_pct = 0;
        do_reset();
        ready_pct = 100;
        t = 0;
        while (n_acc < 2 && t < 20) begin tick(1); t++; end
        ready_pct = 0;
        check("wait_two_accepts", n_acc, 2);
        repeat (5) begin
            tick(1);
            #1;
            check("bp_valid", bus.imem_req_valid, 1);
            check("bp_addr", bus.imem_req_addr, 32'h8);
        end
        ready_pct = 100;
        tick(10);
        // redirect with three in flight, then a second redirect while draining
        lat = 4;
        do_reset();
        t = 0;
        while (pend_addr.size() < 3 && t < 20) begin tick(1); t++; end
        check("wait_three_out", pend_addr.size(), 3);
        h0 = n_hs;
        do_redirect(32'h100);
        tick(20);
        check("drain_done", stale, 0);
        check("redirect_delivered", n_hs > h0, 1);
        t = 0;
        while (pend_addr.size() < 2 && t < 20) begin tick(1); t++; end
        do_redirect(32'h480);
        do_redirect(32'h300);
        tick(20);
        // address wrap and misaligned target
        lat = 1;
        do_redirect(32'hFFFF_FFFC);
        tick(8);
        check("wrap_next_req", exp_req > 32'h0 && exp_req < 32'h100, 1);
        do_redirect(32'h203);
        tick(8);
        // reset with words buffered and requests in flight
        lat = 3;
        ifr_pct = 0;
        t = 0;
        while (!(occ >= 2 && pend_addr.size() >= 1) && t < 30) begin tick(1); t++; end
        check("wait_busy", occ >= 2 && pend_addr.size() >= 1, 1);
        do_reset();
        ifr_pct = 100;
        tick(10);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
                ready_pct = $urandom_range(100, 30);
                ifr_pct = $urandom_range(100, 0);
                lat = $urandom_range(5, 1);
            end
            if ($urandom_range(199) == 0) do_reset();
            else if ($urandom_range(99) < 3)
                do_redirect($urandom_range(3) == 0 ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom);
            else tick(1);
        end
        ready_pct = 100;
        ifr_pct = 100;
        tick(30);
        check("final_drained", stale, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch engine that consumes the program counter and reads instructions from instruction memory over a valid/ready request port with an in-order response port. Fetched words are buffered in a small prefetch FIFO and handed to decode with their PC over a valid/ready handshake. Redirects (branch/jump) flush the buffer and discard stale in-flight responses.

Parameters:
RESET_VALUE, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries (power of two, 2..16)
MAX_OUTSTANDING, 4, max unanswered memory requests (<= FIFO_DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-low reset (sampled on rising clk; 0 = reset)
imem_req_valid  output  1  request address valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  word-aligned fetch address
imem_resp_valid  input  1  response data valid (in order, >=1 cycle after accept, no backpressure)
imem_resp_data  input  32  instruction word
redirect_valid  input  1  flush and restart fetch
redirect_pc  input  32  new fetch address (bits[1:0] forced to 0)
if_valid  output  1  instruction available to decode
if_ready  input  1  decode accepts
if_instr  output  32  instruction
if_pc  output  32  PC of if_instr

Behaviour:
- Reset (rst==0 at clk edge): fetch_pc=RESET_VALUE, FIFO empty, outstanding=0, discard=0, state=FETCH; imem_req_valid=0, if_valid=0, if_instr=0, if_pc=0 (registered outputs), imem_req_addr=RESET_VALUE. Reset mid-transaction drops everything; responses arriving after reset are ignored only via discard counter (see DRAIN) — none expected, memory is reset together.
- Request issue: imem_req_valid=1 when state==FETCH, no redirect this cycle, outstanding<MAX_OUTSTANDING and (fifo_count+outstanding)<FIFO_DEPTH. Addr=fetch_pc. On valid&&ready: fetch_pc+=4 (wraps mod 2^32), outstanding+=1. Addr/valid stable while valid&&!ready.
- Response: each imem_resp_valid decrements outstanding. If discard>0: discard-=1, data dropped. Else word pushed to FIFO with its PC (PC queue tracked alongside; req addr captured at accept). Credit rule guarantees FIFO never overflows; an overflow is an assertion failure.
- Output: if_valid = FIFO non-empty; head shown on if_instr/if_pc. Pop on if_valid&&if_ready. Same-cycle push+pop allowed at full or empty (empty: pushed word appears next cycle, latency response->if_valid = 1 cycle).
- Redirect (priority over everything same cycle): FIFO cleared, fetch_pc=redirect_pc&~3, discard=outstanding minus any response arriving this cycle, request not issued this cycle. If resulting discard>0, state=DRAIN else FETCH.
- DRAIN: no requests; responses dropped until discard==0, then FETCH next cycle. Redirect during DRAIN updates fetch_pc, stays in DRAIN with updated discard.
- States: FETCH, DRAIN. if_valid=0 the cycle after redirect.
- Simultaneous response + redirect: response counted as stale (dropped).

Decomposition:
- Package fetch_pkg: state enum (FETCH, DRAIN), XLEN=32, INSTR_BYTES=4, NOP=32'h0000_0013.
- One sub-module: fetch_fifo (synchronous FIFO, {pc,instr} 64-bit entries, push/pop/clear, count, full/empty; same clk/rst convention).
- Counters widths: $clog2(MAX_OUTSTANDING+1), $clog2(FIFO_DEPTH+1).

Test Plan:
- Reset release, imem always ready, 1-cycle latency, if_ready=1 -> requests 0x0,0x4,0x8...; if_pc sequence 0x0,0x4,0x8 with matching data, one instr per cycle steady state.
- if_ready=0 for 20 cycles -> exactly 4 words buffered, imem_req_valid drops to 0, no overflow; release -> words 0x0..0xC delivered in order, fetch resumes at 0x10.
- imem_req_ready held 0 for 5 cycles -> imem_req_addr stable at 0x8, valid stays 1; no fetch_pc advance.
- 3 requests outstanding (latency 4), redirect_pc=0x100 -> next 3 responses dropped, DRAIN then FETCH, first if_pc=0x100.
- Redirect_pc=0xFFFF_FFFC, run 2 fetches -> addrs 0xFFFF_FFFC then 0x0000_0000 (wrap); redirect_pc=0x203 -> fetch at 0x200.
- rst low for 1 cycle while FIFO full and 2 outstanding -> if_valid=0 next cycle, next request addr=RESET_VALUE.
